// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-in/serial-out bit stream for the sequence detector.
// One-word holding buffer in front of a shift engine; back-to-back words stream seamlessly.
module serial_bit_source #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    logic             bit_end;
    logic             word_end;
    logic             accept;
    logic [WIDTH-1:0] sh_next;

    assign bit_end  = (div_cnt == LAST_DIV);
    assign word_end = bit_end && (bit_cnt == LAST_BIT);
    assign accept   = din_valid && !hold_full;

    // Shift toward whichever end feeds sout, zero-filling behind.
    assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            hold_q    <= '0;
            hold_full <= 1'b0;
            sh_q      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            // Accept and drain never coincide: accept needs hold_full low.
            if (accept) begin
                hold_q    <= din;
                hold_full <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        sh_q      <= hold_q;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bit_end) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else if (!word_end) begin
                        div_cnt <= '0;
                        sh_q    <= sh_next;
                        bit_cnt <= bit_cnt + BW'(1);
                    end else if (hold_full) begin
                        sh_q      <= hold_q;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                    end else begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign din_ready  = !hold_full;
    assign sout_valid = (state == SHIFT);
    assign sout       = (state == SHIFT) &&
                        (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
    assign sout_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign busy       = (state == SHIFT) || hold_full;

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-in/serial-out bit-stream generator that feeds the single-bit input X of the serial sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts bits out one bit period at a time, with no gaps between back-to-back words. It also provides per-bit valid and last-bit markers so the detector stage and the bench can align bits to word boundaries.

## Interface
- WIDTH, 8, word width in bits; must be at least 2.
- DIV, 1, clock cycles per bit period; must be at least 1.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.

- clk  input  1  clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- din  input  WIDTH  word to serialise; sampled on accept.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  holding buffer empty; accept = din_valid & din_ready at rising edge.
- sout  output  1  serial bit, connects to detector X.
- sout_valid  output  1  sout carries a word bit.
- sout_last  output  1  sout carries the final bit of a word; only high while sout_valid is high.
- busy  output  1  shift engine active or holding buffer full.

## Operation
- Storage:
  - Holding register hold_q[WIDTH-1:0] with flag hold_full.
  - Shift register sh_q[WIDTH-1:0].
  - Bit counter bit_cnt, width clog2(WIDTH).
  - Divider div_cnt, width clog2(DIV) (minimum 1).
  - State register.
- States:
  - IDLE: engine empty. sout=0, sout_valid=0.
  - SHIFT: sout = sh_q[WIDTH-1] if MSB_FIRST=1, else sh_q[0]. sout_valid=1.
- din_ready = !hold_full, driven directly from the register with no combinational path from din_valid.
- On accept, din is written to hold_q and hold_full is set.
- bit_end = (div_cnt == DIV-1). div_cnt increments each cycle in SHIFT and wraps to 0 at bit_end.
- On bit_end with bit_cnt < WIDTH-1:
  - Shift sh_q toward the output end, zero-filling.
  - Increment bit_cnt.
- Word end = bit_end with bit_cnt == WIDTH-1. At word end:
  - If hold_full: load sh_q from hold_q, clear hold_full, clear bit_cnt and div_cnt, stay in SHIFT. This gives a seamless stream.
  - Otherwise: go to IDLE.
- In IDLE, if hold_full: load sh_q from hold_q, clear hold_full, clear bit_cnt and div_cnt, go to SHIFT.
- Accept and drain in the same cycle is impossible because din_ready is low while hold_full is set. An accept in the cycle after a drain is legal.
- sout_last = (state==SHIFT) && (bit_cnt == WIDTH-1).
- busy = (state==SHIFT) || hold_full.
- RESET, asserted at any time including mid-word, produces:
  - state=IDLE, hold_full=0, sh_q=0, bit_cnt=0, div_cnt=0.
  - The in-flight word and the buffered word are discarded.
  - Outputs: sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1.
- din_valid while din_ready=0 is ignored. The producer holds din stable until accepted.

## Timing
- Latency:
  - Accept at edge N sets hold_full.
  - Edge N+1 loads sh_q. The first bit appears after edge N+1 and is held DIV cycles.
  - Each bit is held exactly DIV cycles.
  - One word occupies WIDTH*DIV consecutive cycles.
- Back-to-back: if the next word is accepted before the current word's last bit_end, bit 0 of the next word follows the last bit of the current word with zero idle cycles.
- Sustained throughput is one word per WIDTH*DIV cycles. The producer has WIDTH*DIV-1 cycles of slack per word.
- All outputs are functions of registers only. There are no input-to-output combinational paths.
- Reset release: din_ready=1 in the first cycle after RESET deasserts, so the first accept is possible at the first rising edge.

## Test plan
- **Reset values:** assert RESET for 3 cycles, then release -> sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=1.
- **Single word, MSB first:** WIDTH=8, DIV=1, MSB_FIRST=1, accept din=8'hC6 at edge N -> from edge N+1, sout = 1,1,0,0,0,1,1,0 on 8 consecutive cycles. sout_last is high only on the 8th cycle. sout_valid drops at edge N+9.
- **Back-to-back, LSB first with divider:** MSB_FIRST=0, DIV=3, words 8'h01 then 8'h80, second word offered as soon as din_ready rises -> bit 0 of the first word held 3 cycles (1), then zeros. The stream continues into 8'h80 with no gap: seven 0 bits, then a 1 held 3 cycles. Total 48 valid cycles.
- **Handshake stall:** hold din_valid=1 with din=8'hAA while busy -> din_ready stays low until the held word moves into the shift register. Exactly one extra word is accepted per drain, and no word is duplicated or dropped over 4 words.
- **Reset mid-word:** assert RESET after the 3rd bit of 8'hFF with a second word buffered -> outputs return to reset values immediately. After release, no residual bits appear. A new word 8'h0F serialises correctly from bit 0.
- **End-to-end with detector:** serialise 8'hDB (11011011, MSB first, DIV=1) into the detector X -> detector Z pulses exactly twice. Each pulse falls in the cycle carrying a 0 bit that follows a 1,1 pair.
